// File: rtl/calc_disp_pkg.sv
// Shared types and helpers for the calculator display scanner.
// Digit indexing: 0 is the least-significant digit.
package calc_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] MINUS_CODE = 4'hF;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    typedef struct packed {
        logic [15:0] digits;
        logic        neg;
        logic        mark;
        digit_idx_t  mark_pos;
    } disp_val_t;

    // 1 + position of the highest nonzero nibble; a zero value counts as 1
    function automatic logic [2:0] sig_count(input logic [15:0] d);
        logic [2:0] s;
        s = 3'd1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (d[4*i +: 4] != 4'h0) s = 3'(i + 1);
        end
        return s;
    endfunction

    function automatic logic is_hole(input logic [3:0] n);
        return (n >= 4'hA) && (n <= 4'hE);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts clocks within one digit slot,
// flags the last cycle (tick) and the anti-ghost guard window.
module scan_tick_gen #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic in_guard
);

    localparam int W = $clog2(REFRESH_DIV);

    logic [W-1:0] cnt;

    assign tick     = (cnt == W'(REFRESH_DIV - 1));
    assign in_guard = (cnt < W'(BLANK_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit multiplexed scanner feeding the sdcc seven-segment decoder:
// shadow/active value registers, blanking, sign placement, anode drive.
module disp_scan_ctrl
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        neg_in,
    input  logic        dp_en,
    input  logic [1:0]  dp_pos,
    input  logic        blank_lz,
    output logic [3:0]  digit_code,
    output logic        seg_en,
    output logic        dp_on,
    output logic [3:0]  an,
    output logic        upd_done,
    output logic        ovf
);

    logic       tick;
    logic       in_guard;
    digit_idx_t idx;
    disp_val_t  shadow;
    disp_val_t  active;
    logic       pending;
    logic       valid;
    logic       xfer;

    logic [2:0] sig;
    logic [3:0] nib;
    logic       show;
    logic [3:0] code;
    logic       lit;

    scan_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .in_guard(in_guard)
    );

    // Frame boundary: last cycle of slot 3
    assign xfer = tick && (idx == 2'd3) && pending;

    assign sig = sig_count(active.digits);
    assign nib = active.digits[{idx, 2'b00} +: 4];
    assign lit = valid && !in_guard;

    always_comb begin
        show = 1'b0;
        code = 4'h0;
        if (active.neg && (sig != 3'd4) && ({1'b0, idx} == sig)) begin
            show = 1'b1;
            code = MINUS_CODE;
        end else if (blank_lz && ({1'b0, idx} >= sig)) begin
            show = 1'b0;
        end else if (is_hole(nib)) begin
            show = 1'b0;
        end else begin
            show = 1'b1;
            code = nib;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            upd_done   <= 1'b0;
            an         <= AN_OFF;
            seg_en     <= 1'b0;
            digit_code <= 4'h0;
            dp_on      <= 1'b0;
        end else begin
            if (tick) idx <= idx + 2'd1;
            if (load) begin
                shadow <= '{digits: digits_in, neg: neg_in,
                            mark: dp_en, mark_pos: dp_pos};
            end
            // A load landing on the transfer cycle keeps pending set
            if (load) begin
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end
            if (xfer) begin
                active <= shadow;
                valid  <= 1'b1;
                ovf    <= shadow.neg && (sig_count(shadow.digits) == 3'd4);
            end
            upd_done   <= xfer;
            an         <= lit ? ~(4'b0001 << idx) : AN_OFF;
            seg_en     <= lit && show;
            digit_code <= (lit && show) ? code : 4'h0;
            dp_on      <= lit && active.mark && (active.mark_pos == idx);
        end
    end

endmodule
